// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for the 5-stage RV32IM pipeline. Drives the
// load enables and synchronous bubble-insert controls of the PC and the four
// pipeline registers. It resolves three hazards:
//   - load-use: one-cycle bubble between the load in EX and its consumer in ID
//   - taken branch/jump in EX: squash the two younger instructions
//   - multi-cycle DIV/REM: freeze the front end while the divider is busy
// It also keeps wrap-around counters of stall cycles and redirect flushes.
//
// Ports:
//   clk, async_rst_n          clock, asynchronous active-low reset
//   ID_R1_read/ID_R2_read     ID instruction reads rs1/rs2
//   ID_rs1/ID_rs2             ID source register indices
//   EX_mem_read               EX instruction is a load
//   EX_reg_write, EX_rd       EX instruction writes register EX_rd
//   EX_redirect               EX resolved a taken branch/jump this cycle
//   EX_is_div                 EX instruction is DIV/DIVU/REM/REMU
//   PC_en, *_en               PC and pipeline register load enables
//   *_sync_rst                insert a bubble at the next edge (beats *_en)
//   div_busy                  divide sequencer is in its busy state
//   stall_cycles              edges on which PC_en was low (wraps)
//   flush_count               edges on which a redirect flush was applied (wraps)
//
// All control outputs are combinational from the inputs and the registered
// sequencer state; only the sequencer and the counters are clocked.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int DIV_LATENCY = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             ID_R1_read,
  input  logic             ID_R2_read,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             EX_mem_read,
  input  logic             EX_reg_write,
  input  logic [4:0]       EX_rd,
  input  logic             EX_redirect,
  input  logic             EX_is_div,
  output logic             PC_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_sync_rst,
  output logic             ID_EX_sync_rst,
  output logic             EX_MEM_sync_rst,
  output logic             MEM_WB_sync_rst,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Counter sized so it can hold DIV_LATENCY-2 (DIV_LATENCY >= 2 keeps this >= 1).
  localparam int CW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_START = CW'(DIV_LATENCY - 2);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_DIV_BUSY = 1'b1
  } div_state_e;

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_last_div_cycle;
  logic w_freeze;
  logic w_redirect_apply;
  logic w_load_use_apply;

  // Load-use detection: the load in EX produces a register the ID instruction reads.
  always_comb begin
    w_rs1_hit  = ID_R1_read & (ID_rs1 == EX_rd);
    w_rs2_hit  = ID_R2_read & (ID_rs2 == EX_rd);
    w_load_use = EX_mem_read & EX_reg_write & (EX_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
  end

  // Hazard arbitration: freeze beats redirect beats load-use.
  always_comb begin
    // The final cycle of a divide (busy with count exhausted) is not frozen:
    // the divide leaves EX at that edge.
    w_last_div_cycle = (r_state == S_DIV_BUSY) & (r_cnt == CNT_ZERO);
    w_freeze         = EX_is_div & ~w_last_div_cycle;
    w_redirect_apply = EX_redirect & ~w_freeze;
    // A redirect squashes the ID instruction, so its load-use stall is moot.
    w_load_use_apply = w_load_use & ~w_freeze & ~EX_redirect;
  end

  // Divide sequencer next-state and countdown.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (EX_is_div) begin
          w_state_nxt = S_DIV_BUSY;
          w_cnt_nxt   = CNT_START;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      S_DIV_BUSY: begin
        if (EX_is_div && (r_cnt != CNT_ZERO)) begin
          w_state_nxt = S_DIV_BUSY;
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end else begin
          // Either the divide completes now, or the divide vanished from EX
          // (abnormal); both return to idle without asserting anything.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Divide sequencer state register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pipeline register controls; while reset is held every stage is flushed.
  always_comb begin
    PC_en           = 1'b1;
    IF_ID_en        = 1'b1;
    ID_EX_en        = 1'b1;
    EX_MEM_en       = 1'b1;
    MEM_WB_en       = 1'b1;
    IF_ID_sync_rst  = 1'b0;
    ID_EX_sync_rst  = 1'b0;
    EX_MEM_sync_rst = 1'b0;
    MEM_WB_sync_rst = 1'b0;
    if (!async_rst_n) begin
      IF_ID_sync_rst  = 1'b1;
      ID_EX_sync_rst  = 1'b1;
      EX_MEM_sync_rst = 1'b1;
      MEM_WB_sync_rst = 1'b1;
    end else if (w_freeze) begin
      // Hold PC, IF/ID and ID/EX; the divide stays in EX and a bubble
      // goes to MEM each cycle.
      PC_en           = 1'b0;
      IF_ID_en        = 1'b0;
      ID_EX_en        = 1'b0;
      EX_MEM_sync_rst = 1'b1;
    end else if (w_redirect_apply) begin
      // PC loads the target; the two wrong-path instructions are squashed.
      PC_en           = 1'b1;
      IF_ID_sync_rst  = 1'b1;
      ID_EX_sync_rst  = 1'b1;
    end else if (w_load_use_apply) begin
      // Hold the consumer in ID one cycle and send a bubble into EX.
      PC_en           = 1'b0;
      IF_ID_en        = 1'b0;
      ID_EX_sync_rst  = 1'b1;
    end else begin
      PC_en           = 1'b1;
    end
  end

  // Performance counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_stall_cycles <= {CNT_W{1'b0}};
      r_flush_count  <= {CNT_W{1'b0}};
    end else begin
      if (!PC_en) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end else begin
        r_stall_cycles <= r_stall_cycles;
      end
      if (w_redirect_apply) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign div_busy     = (r_state == S_DIV_BUSY);
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. Each scenario task drives ID/EX
// status, pushes the expected control vector onto a scoreboard queue and, at
// the following negative clock edge, pops and compares it against the DUT.
// A second instance with CNT_W=4 shares the inputs and checks counter wrap.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  // {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
  //  IF_ID_sync_rst, ID_EX_sync_rst, EX_MEM_sync_rst, MEM_WB_sync_rst}
  localparam logic [8:0] C_NORM = 9'b11111_0000;
  localparam logic [8:0] C_LU   = 9'b00111_0100;
  localparam logic [8:0] C_RD   = 9'b11111_1100;
  localparam logic [8:0] C_FRZ  = 9'b00011_0010;
  localparam logic [8:0] C_RST  = 9'b11111_1111;

  typedef logic [73:0] vec_t; // {ctl[8:0], div_busy, stall[31:0], flush[31:0]}

  logic clk = 1'b0;
  logic async_rst_n = 1'b0;
  logic ID_R1_read = 1'b0, ID_R2_read = 1'b0;
  logic [4:0] ID_rs1 = 5'd0, ID_rs2 = 5'd0, EX_rd = 5'd0;
  logic EX_mem_read = 1'b0, EX_reg_write = 1'b0, EX_redirect = 1'b0, EX_is_div = 1'b0;

  logic PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic IF_ID_sync_rst, ID_EX_sync_rst, EX_MEM_sync_rst, MEM_WB_sync_rst;
  logic div_busy;
  logic [31:0] stall_cycles, flush_count;

  logic s_PC_en, s_IF_ID_en, s_ID_EX_en, s_EX_MEM_en, s_MEM_WB_en;
  logic s_IF_ID_sync_rst, s_ID_EX_sync_rst, s_EX_MEM_sync_rst, s_MEM_WB_sync_rst;
  logic s_div_busy;
  logic [3:0] s_stall_cycles, s_flush_count;

  logic [8:0] obs_ctl;
  assign obs_ctl = {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                    IF_ID_sync_rst, ID_EX_sync_rst, EX_MEM_sync_rst, MEM_WB_sync_rst};

  vec_t exp_q[$];
  logic [31:0] exp_stall = 32'd0;
  logic [31:0] exp_flush = 32'd0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DIV_LATENCY(8), .CNT_W(32)) dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .ID_R1_read(ID_R1_read), .ID_R2_read(ID_R2_read),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .EX_mem_read(EX_mem_read), .EX_reg_write(EX_reg_write), .EX_rd(EX_rd),
    .EX_redirect(EX_redirect), .EX_is_div(EX_is_div),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en),
    .EX_MEM_en(EX_MEM_en), .MEM_WB_en(MEM_WB_en),
    .IF_ID_sync_rst(IF_ID_sync_rst), .ID_EX_sync_rst(ID_EX_sync_rst),
    .EX_MEM_sync_rst(EX_MEM_sync_rst), .MEM_WB_sync_rst(MEM_WB_sync_rst),
    .div_busy(div_busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.DIV_LATENCY(8), .CNT_W(4)) dut_small (
    .clk(clk), .async_rst_n(async_rst_n),
    .ID_R1_read(ID_R1_read), .ID_R2_read(ID_R2_read),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .EX_mem_read(EX_mem_read), .EX_reg_write(EX_reg_write), .EX_rd(EX_rd),
    .EX_redirect(EX_redirect), .EX_is_div(EX_is_div),
    .PC_en(s_PC_en), .IF_ID_en(s_IF_ID_en), .ID_EX_en(s_ID_EX_en),
    .EX_MEM_en(s_EX_MEM_en), .MEM_WB_en(s_MEM_WB_en),
    .IF_ID_sync_rst(s_IF_ID_sync_rst), .ID_EX_sync_rst(s_ID_EX_sync_rst),
    .EX_MEM_sync_rst(s_EX_MEM_sync_rst), .MEM_WB_sync_rst(s_MEM_WB_sync_rst),
    .div_busy(s_div_busy), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // Drive one cycle's worth of ID/EX status.
  task automatic drive(input logic mr, input logic rw, input logic [4:0] rd,
                       input logic r1, input logic [4:0] rs1,
                       input logic r2, input logic [4:0] rs2,
                       input logic redir, input logic div);
    EX_mem_read  = mr;
    EX_reg_write = rw;
    EX_rd        = rd;
    ID_R1_read   = r1;
    ID_rs1       = rs1;
    ID_R2_read   = r2;
    ID_rs2       = rs2;
    EX_redirect  = redir;
    EX_is_div    = div;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Queue the expected outputs for this cycle, then advance the expected
  // counters for the edge that closes it.
  task automatic push_exp(input logic [8:0] ctl, input logic busy, input logic flush_ev);
    exp_q.push_back({ctl, busy, exp_stall, exp_flush});
    if (ctl[8] == 1'b0) exp_stall = exp_stall + 32'd1;
    if (flush_ev) exp_flush = exp_flush + 32'd1;
  endtask

  task automatic test_reset();
    vec_t got, want;
    idle();
    async_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
    push_exp(C_RST, 1'b0, 1'b0);
    got = {obs_ctl, div_busy, stall_cycles, flush_count};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected %h", got, want);
    end
    @(negedge clk);
    async_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      push_exp(C_NORM, 1'b0, 1'b0);
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    vec_t got, want;
    logic [8:0] ectl;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0); ectl = C_LU; end
        1: begin idle(); ectl = C_NORM; end
        2: begin drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); ectl = C_NORM; end
        3: begin drive(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0); ectl = C_LU; end
        4: begin drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0); ectl = C_NORM; end
        5: begin drive(1'b1, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0); ectl = C_NORM; end
        6: begin drive(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0); ectl = C_NORM; end
        default: begin drive(1'b1, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 1'b0); ectl = C_LU; end
      endcase
      push_exp(ectl, 1'b0, 1'b0);
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    vec_t got, want;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
          push_exp(C_RD, 1'b0, 1'b1);
        end
        1: begin
          drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
          push_exp(C_RD, 1'b0, 1'b1);
        end
        default: begin
          idle();
          push_exp(C_NORM, 1'b0, 1'b0);
        end
      endcase
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL redirect[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // One divide held for 8 cycles; a redirect + load-use in the middle must lose to the freeze.
  task automatic test_div();
    vec_t got, want;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        idle();
        push_exp(C_NORM, 1'b0, 1'b0);
      end else begin
        if (i == 2) drive(1'b1, 1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1);
        else        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        push_exp((i < 7) ? C_FRZ : C_NORM, (i != 0), 1'b0);
      end
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL div[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t got, want;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        idle();
        push_exp(C_NORM, 1'b0, 1'b0);
      end else begin
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        push_exp(((i % 8) != 7) ? C_FRZ : C_NORM, ((i % 8) != 0), 1'b0);
      end
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // Divide disappears from EX after one cycle: sequencer drops back without asserting anything.
  task automatic test_div_abort();
    vec_t got, want;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
        push_exp(C_FRZ, 1'b0, 1'b0);
      end else begin
        idle();
        push_exp(C_NORM, (i == 1), 1'b0);
      end
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL div_abort[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_div();
    vec_t got, want;
    // Four edges into a divide the countdown sits at 3.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      push_exp(C_FRZ, (i != 0), 1'b0);
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mid_div_run[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
    async_rst_n = 1'b0;
    #1;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
    push_exp(C_RST, 1'b0, 1'b0);
    got = {obs_ctl, div_busy, stall_cycles, flush_count};
    want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL mid_div_reset: got %h expected %h", got, want);
    end
    idle();
    @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      push_exp(C_NORM, 1'b0, 1'b0);
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL after_mid_reset[%0d]: got %h expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // 16 consecutive stalls: the 4-bit counter reaches 4'hF, then wraps to 0.
  task automatic test_wrap();
    vec_t got, want;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        idle();
        push_exp(C_NORM, 1'b0, 1'b0);
      end else begin
        drive(1'b1, 1'b1, 5'd12, 1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0);
        push_exp(C_LU, 1'b0, 1'b0);
      end
      @(negedge clk);
      got = {obs_ctl, div_busy, stall_cycles, flush_count};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %h expected %h", i, got, want);
      end
      n_checks++;
      if (s_stall_cycles !== want[35:32]) begin
        n_fail++;
        $display("FAIL wrap_small[%0d]: got %h expected %h", i, s_stall_cycles, want[35:32]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_div();
    test_back_to_back();
    test_div_abort();
    test_reset_mid_div();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
